// File: rtl/ntt_loop_ctrl.sv
// Job sequencer for the NTT address generator: LOAD, LAYERS transform passes, then UNLOAD.
// Drives mode/newloop, consumes ctr_sig, and times the IN/OUT phases with its own counter.
module ntt_loop_ctrl #(
    parameter int LAYERS    = 8,
    parameter int IO_CYCLES = 514
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    input  logic       abort,
    input  logic       ctr_sig,
    output logic [1:0] mode,
    output logic       newloop,
    output logic [3:0] layer,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(IO_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] XFORM  = 2'd2;
    localparam logic [1:0] UNLOAD = 2'd3;

    localparam logic [1:0] MODE_IN  = 2'b10;
    localparam logic [1:0] MODE_OUT = 2'b11;

    localparam logic [CW-1:0] IO_LAST    = CW'(IO_CYCLES - 1);
    localparam logic [3:0]    LAYER_LAST = 4'(LAYERS - 1);

    logic [1:0]    state, state_d;
    logic [CW-1:0] io_cnt, io_cnt_d;
    logic          inv_q, inv_d;
    logic [1:0]    mode_d;
    logic          newloop_d;
    logic [3:0]    layer_d;
    logic          busy_d;
    logic          done_d;
    logic          io_phase;
    logic          io_last;

    // The IN/OUT counter only advances on newloop-low cycles, so the value left
    // over from a previous phase can never fire during a phase's newloop cycle.
    always_comb begin
        io_phase = (state == LOAD) || (state == UNLOAD);
        io_last  = io_phase && !newloop && (io_cnt == IO_LAST);
        io_cnt_d = '0;
        if (io_phase && !newloop) begin
            io_cnt_d = io_cnt + CW'(1);
        end
    end

    // A newloop pulse is never requested in a cycle that already carries one:
    // start right after an abort waits a cycle, and an abort landing on a
    // newloop cycle returns to IDLE without a second pulse.
    always_comb begin
        state_d   = state;
        inv_d     = inv_q;
        mode_d    = mode;
        layer_d   = layer;
        busy_d    = busy;
        newloop_d = 1'b0;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !newloop) begin
                    inv_d     = inv;
                    newloop_d = 1'b1;
                    mode_d    = MODE_IN;
                    busy_d    = 1'b1;
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                if (abort) begin
                    newloop_d = !newloop;
                    mode_d    = MODE_IN;
                    layer_d   = 4'd0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (io_last) begin
                    newloop_d = 1'b1;
                    mode_d    = {1'b0, inv_q};
                    layer_d   = 4'd0;
                    state_d   = XFORM;
                end
            end

            XFORM: begin
                if (abort) begin
                    newloop_d = !newloop;
                    mode_d    = MODE_IN;
                    layer_d   = 4'd0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (ctr_sig && !newloop) begin
                    newloop_d = 1'b1;
                    if (layer == LAYER_LAST) begin
                        mode_d  = MODE_OUT;
                        state_d = UNLOAD;
                    end else begin
                        layer_d = layer + 4'd1;
                    end
                end
            end

            UNLOAD: begin
                if (abort) begin
                    newloop_d = !newloop;
                    mode_d    = MODE_IN;
                    layer_d   = 4'd0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (io_last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    mode_d  = MODE_IN;
                    layer_d = 4'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            io_cnt  <= '0;
            inv_q   <= 1'b0;
            mode    <= MODE_IN;
            newloop <= 1'b0;
            layer   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            io_cnt  <= io_cnt_d;
            inv_q   <= inv_d;
            mode    <= mode_d;
            newloop <= newloop_d;
            layer   <= layer_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Directed bench for ntt_loop_ctrl with a behavioural address-generator model
// that holds ctr_sig through the newloop cycle, so stale flags are always exercised.
module tb_ntt_loop_ctrl;

    localparam int LAYERS    = 8;
    localparam int IO_CYCLES = 514;
    localparam int GEN_LAT   = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic       inv;
    logic       abort;
    logic       ctr_sig;
    logic [1:0] mode;
    logic       newloop;
    logic [3:0] layer;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         nl_cyc_q[$];
    logic [1:0] nl_mode_q[$];
    logic [3:0] nl_layer_q[$];
    int         done_q[$];
    int         consec_nl = 0;
    int         done_bad  = 0;
    logic       prev_nl   = 1'b0;
    logic       prev_busy = 1'b0;

    int start_cyc;
    int nl_base;
    int done_base;

    ntt_loop_ctrl #(
        .LAYERS   (LAYERS),
        .IO_CYCLES(IO_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .inv    (inv),
        .abort  (abort),
        .ctr_sig(ctr_sig),
        .mode   (mode),
        .newloop(newloop),
        .layer  (layer),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Records every newloop pulse with the mode/layer it carried, and every done.
    always @(negedge clk) begin
        if (newloop) begin
            nl_cyc_q.push_back(cyc);
            nl_mode_q.push_back(mode);
            nl_layer_q.push_back(layer);
            if (prev_nl) consec_nl++;
        end
        if (done) begin
            done_q.push_back(cyc);
            if (busy || !prev_busy) done_bad++;
        end
        prev_nl   = newloop;
        prev_busy = busy;
    end

    // Address generator: raises ctr_sig GEN_LAT cycles into a transform layer and
    // keeps it high until the cycle after newloop.
    initial begin
        int gen_cnt;
        gen_cnt = 0;
        ctr_sig = 1'b0;
        forever begin
            @(negedge clk);
            if (newloop) begin
                gen_cnt = 0;
            end else if (!mode[1]) begin
                gen_cnt++;
                ctr_sig = (gen_cnt > GEN_LAT);
            end else begin
                gen_cnt = 0;
                ctr_sig = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Issues a one-cycle start from the current (negedge+1) point in time.
    task automatic applyStimulus(input logic inv_v);
        start_cyc = cyc;
        nl_base   = nl_cyc_q.size();
        done_base = done_q.size();
        start     = 1'b1;
        inv       = inv_v;
        @(negedge clk); #1;
        start     = 1'b0;
    endtask

    // With poke set, start is re-asserted in LOAD and XFORM and inv keeps toggling.
    task automatic waitDone(input bit poke);
        bit seen;
        int rel;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_q.size() > done_base) begin
                seen = 1'b1;
                break;
            end
            rel = cyc - start_cyc;
            if (poke) begin
                start = (rel == 100) || (rel == 530);
                if (rel % 40 == 0) inv = ~inv;
            end
        end
        start = 1'b0;
        checkOutput("job_finished", int'(seen), 1);
    endtask

    task automatic checkJob(input logic inv_v, input string name);
        int pulses;
        int exp_mode;
        int exp_layer;
        pulses = nl_cyc_q.size() - nl_base;
        checkOutput({name, "_pulse_count"}, pulses, LAYERS + 2);
        checkOutput({name, "_done_count"}, done_q.size() - done_base, 1);
        if (pulses == LAYERS + 2) begin
            checkOutput({name, "_first_nl_cycle"}, nl_cyc_q[nl_base] - start_cyc, 1);
            checkOutput({name, "_second_nl_cycle"}, nl_cyc_q[nl_base + 1] - start_cyc, 516);
            for (int k = 0; k < LAYERS + 2; k++) begin
                if (k == 0) begin
                    exp_mode  = 2;
                    exp_layer = 0;
                end else if (k == LAYERS + 1) begin
                    exp_mode  = 3;
                    exp_layer = LAYERS - 1;
                end else begin
                    exp_mode  = int'(inv_v);
                    exp_layer = k - 1;
                end
                checkOutput($sformatf("%s_pulse%0d_mode", name, k), int'(nl_mode_q[nl_base + k]), exp_mode);
                checkOutput($sformatf("%s_pulse%0d_layer", name, k), int'(nl_layer_q[nl_base + k]), exp_layer);
            end
            if (done_q.size() > done_base) begin
                checkOutput({name, "_done_cycle"}, done_q[done_base] - nl_cyc_q[nl_base + LAYERS + 1], IO_CYCLES + 1);
            end
        end
        checkOutput({name, "_busy_after"}, int'(busy), 0);
        checkOutput({name, "_mode_after"}, int'(mode), 2);
    endtask

    task automatic waitLayer(input int target, input bit need_flag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (layer == 4'(target) && mode[1] == 1'b0 && !newloop && (!need_flag || ctr_sig)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int dbase;
        rst   = 1'b1;
        start = 1'b0;
        inv   = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_mode", int'(mode), 2);
        checkOutput("reset_newloop", int'(newloop), 0);
        checkOutput("reset_layer", int'(layer), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Plain NTT job.
        applyStimulus(1'b0);
        waitDone(1'b0);
        checkJob(1'b0, "ntt");

        // INTT started in the done cycle; start and inv are poked mid-job.
        applyStimulus(1'b1);
        checkOutput("b2b_first_nl", nl_cyc_q.size() > nl_base ? nl_cyc_q[nl_base] - done_q[done_q.size() - 1] : -1, 1);
        waitDone(1'b1);
        checkJob(1'b1, "intt");

        // Synchronous reset in the middle of layer 3.
        repeat (3) @(negedge clk);
        #1;
        applyStimulus(1'b0);
        waitLayer(3, 1'b0, ok);
        checkOutput("reach_layer3", int'(ok), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("midrst_mode", int'(mode), 2);
        checkOutput("midrst_layer", int'(layer), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_newloop", int'(newloop), 0);
        checkOutput("midrst_done", int'(done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Abort at layer 5 in the same cycle as a genuine ctr_sig.
        applyStimulus(1'b0);
        waitLayer(5, 1'b1, ok);
        checkOutput("reach_layer5", int'(ok), 1);
        dbase = done_q.size();
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_newloop", int'(newloop), 1);
        checkOutput("abort_mode", int'(mode), 2);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_layer", int'(layer), 0);
        checkOutput("abort_done", int'(done), 0);
        @(negedge clk); #1;
        checkOutput("abort_newloop_drop", int'(newloop), 0);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("abort_no_done", done_q.size() - dbase, 0);

        // Fresh job after the abort.
        applyStimulus(1'b1);
        waitDone(1'b0);
        checkJob(1'b1, "post_abort");

        checkOutput("no_consecutive_newloop", consec_nl, 0);
        checkOutput("done_with_busy_fall", done_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
